// File: rtl/dt_feature_sequencer_pkg.sv
// Shared definitions for the decision-tree feature sequencer.
// Data width default, FSM encodings and default timeout.
`ifndef DataWidth
`define DataWidth 8
`endif

package dt_feature_sequencer_pkg;

  localparam int DATA_W_DEF  = `DataWidth;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/dt_seq_if.sv
// Upstream, tree-side and result-side signals of the sequencer.
// slave is the sequencer's view, master is the environment's.
interface dt_seq_if
  import dt_feature_sequencer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W  = 4
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] x1_in_i;
  logic [DATA_W-1:0] x2_in_i;
  logic [DATA_W-1:0] x3_in_i;
  logic              dt_start_o;
  logic [DATA_W-1:0] dt_x1_o;
  logic [DATA_W-1:0] dt_x2_o;
  logic [DATA_W-1:0] dt_x3_o;
  logic [DATA_W-1:0] dt_y_i;
  logic              dt_y_valid_i;
  logic              res_valid_o;
  logic              res_ready_i;
  logic [DATA_W-1:0] res_y_o;
  logic [TAG_W-1:0]  res_tag_o;
  logic              res_err_o;
  logic              busy_o;

  modport slave (
    input  in_valid_i, x1_in_i, x2_in_i, x3_in_i,
    input  dt_y_i, dt_y_valid_i, res_ready_i,
    output in_ready_o, dt_start_o,
    output dt_x1_o, dt_x2_o, dt_x3_o,
    output res_valid_o, res_y_o, res_tag_o,
    output res_err_o, busy_o
  );

  modport master (
    output in_valid_i, x1_in_i, x2_in_i, x3_in_i,
    output dt_y_i, dt_y_valid_i, res_ready_i,
    input  in_ready_o, dt_start_o,
    input  dt_x1_o, dt_x2_o, dt_x3_o,
    input  res_valid_o, res_y_o, res_tag_o,
    input  res_err_o, busy_o
  );
endinterface

// File: rtl/dt_seq_fifo.sv
// Synchronous FIFO with combinational head; push+pop on an empty
// FIFO passes din straight through so the count stays unchanged.
module dt_seq_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);

  assign do_push = push && (!full || pop);
  assign do_pop  = pop && (!empty || push);

  assign dout = empty ? din : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/dt_feature_sequencer.sv
// Feeds buffered feature triples to the decision tree one at a time
// and returns each tagged result, abandoning hung requests.
module dt_feature_sequencer
  import dt_feature_sequencer_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic  clock,
  input  logic  reset,
  dt_seq_if.slave bus
);
  localparam int FW = 3*DATA_W + TAG_W;
  localparam int CW = $clog2(TIMEOUT) + 1;

  seq_state_e        state_q, state_d;
  logic [CW-1:0]     tmo_q, tmo_d;
  logic [TAG_W-1:0]  cnt_q, cnt_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] x1_q, x1_d;
  logic [DATA_W-1:0] x2_q, x2_d;
  logic [DATA_W-1:0] x3_q, x3_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic              err_q, err_d;

  logic [FW-1:0] f_din, f_dout;
  logic          f_full, f_empty;
  logic          push, pop;

  assign push  = bus.in_valid_i && !f_full;
  assign pop   = (state_q == ST_IDLE) && !f_empty;
  assign f_din = {bus.x1_in_i, bus.x2_in_i,
                  bus.x3_in_i, cnt_q};

  dt_seq_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (f_din),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty)
  );

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    cnt_d   = push ? cnt_q + 1'b1 : cnt_q;
    tag_d   = tag_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    x3_d    = x3_q;
    y_d     = y_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (!f_empty) begin
          {x1_d, x2_d, x3_d, tag_d} = f_dout;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmo_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        tmo_d = tmo_q + 1'b1;
        // a valid tree answer beats an expiring timeout
        if (bus.dt_y_valid_i) begin
          y_d     = bus.dt_y_i;
          err_d   = 1'b0;
          state_d = ST_HOLD;
        end else if (tmo_d == CW'(TIMEOUT-1)) begin
          y_d     = '0;
          err_d   = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.res_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tmo_q   <= '0;
      cnt_q   <= '0;
      tag_q   <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      x3_q    <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      x3_q    <= x3_d;
      y_q     <= y_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready_o  = !f_full;
  assign bus.dt_start_o  = (state_q == ST_ISSUE);
  assign bus.dt_x1_o     = x1_q;
  assign bus.dt_x2_o     = x2_q;
  assign bus.dt_x3_o     = x3_q;
  assign bus.res_valid_o = (state_q == ST_HOLD);
  assign bus.res_y_o     = y_q;
  assign bus.res_tag_o   = tag_q;
  assign bus.res_err_o   = err_q;
  assign bus.busy_o      = (state_q != ST_IDLE) || !f_empty;
endmodule

// File: tb/tb_dt_feature_sequencer.sv
// Bench for dt_feature_sequencer: transaction-level model checked
// every cycle, a scripted tree responder and literal spot checks.
module tb_dt_feature_sequencer;
  localparam int DW    = 8;
  localparam int TW    = 4;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [3:0] tag;
  } ent_t;

  typedef struct packed {
    logic [7:0] y;
    logic [3:0] tag;
    logic       err;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dt_seq_if #(.DATA_W(DW), .TAG_W(TW)) bus ();

  dt_feature_sequencer #(
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH),
    .TAG_W      (TW),
    .TIMEOUT    (TMO)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int         lat [64];
  logic [7:0] yv  [64];
  int         nreq    = 0;
  bit         ty_pend = 0;
  int         ty_cyc  = 0;
  logic [7:0] ty_val  = 8'h00;
  bit         stray   = 0;

  res_t rlog[$];
  int   start_log[$];
  int   first_log[$];
  int   hs_log[$];

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               n, act, exp, cyc);
    end
  endtask

  // Tree responder: answers request n lat[n] cycles after its start.
  initial begin
    bus.dt_y_valid_i = 1'b0;
    bus.dt_y_i       = 8'h00;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (ty_pend && cyc == ty_cyc) begin
        bus.dt_y_valid_i = 1'b1;
        bus.dt_y_i       = ty_val;
        ty_pend          = 0;
      end else begin
        bus.dt_y_valid_i = stray;
        bus.dt_y_i       = stray ? 8'hEE : 8'h00;
      end
      if (bus.dt_start_o === 1'b1) begin
        if (lat[nreq] > 0) begin
          ty_pend = 1;
          ty_cyc  = cyc + lat[nreq];
          ty_val  = yv[nreq];
        end
        nreq++;
      end
    end
  end

  // Transaction-level model, compared on every falling edge.
  ent_t       fq[$];
  ent_t       cur   = '0;
  res_t       res   = '0;
  bit         infl  = 0;
  bit         have  = 0;
  bit         armed = 0;
  bit         prev_v = 0;
  int         st_c  = 0;
  logic [3:0] tagc  = 4'd0;

  always @(negedge clk) begin
    bit do_pop;
    bit do_push;
    if (armed) begin
      chk("in_ready", 32'(bus.in_ready_o), 32'(fq.size() < DEPTH));
      chk("dt_start", 32'(bus.dt_start_o), 32'(infl && cyc == st_c));
      chk("res_valid", 32'(bus.res_valid_o), 32'(have));
      chk("busy", 32'(bus.busy_o), 32'(infl || fq.size() > 0));
      chk("dt_x", {bus.dt_x1_o, bus.dt_x2_o, bus.dt_x3_o},
          {cur.a, cur.b, cur.c});
      if (have)
        chk("result", {bus.res_y_o, bus.res_tag_o, bus.res_err_o},
            32'(res));
    end
    if (bus.dt_start_o === 1'b1) start_log.push_back(cyc);
    if (bus.res_valid_o === 1'b1 && !prev_v) first_log.push_back(cyc);
    prev_v = (bus.res_valid_o === 1'b1);
    if (bus.res_valid_o === 1'b1 && bus.res_ready_i === 1'b1) begin
      hs_log.push_back(cyc);
      rlog.push_back({bus.res_y_o, bus.res_tag_o, bus.res_err_o});
    end
    if (rst) begin
      fq.delete();
      infl  = 0;
      have  = 0;
      tagc  = 4'd0;
      cur   = '0;
      armed = 1;
    end else if (armed) begin
      do_pop  = !infl && fq.size() > 0;
      do_push = bus.in_valid_i && fq.size() < DEPTH;
      if (have && bus.res_ready_i) begin
        infl = 0;
        have = 0;
      end else if (infl && !have && cyc > st_c) begin
        if (bus.dt_y_valid_i) begin
          have = 1;
          res  = {bus.dt_y_i, cur.tag, 1'b0};
        end else if (cyc == st_c + TMO - 1) begin
          have = 1;
          res  = {8'h00, cur.tag, 1'b1};
        end
      end
      if (do_pop) begin
        cur  = fq.pop_front();
        infl = 1;
        st_c = cyc + 1;
      end
      if (do_push) begin
        fq.push_back({bus.x1_in_i, bus.x2_in_i, bus.x3_in_i, tagc});
        tagc++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [7:0] a, b, c);
    bit ok = 0;
    bus.in_valid_i = 1'b1;
    bus.x1_in_i = a;
    bus.x2_in_i = b;
    bus.x3_in_i = c;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = (bus.in_ready_o === 1'b1);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL push_wait: in_ready stayed 0 (cycle %0d)", cyc);
    end
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    bit ok = 0;
    for (int k = 0; k < lim && !ok; k++) begin
      @(negedge clk);
      ok = (bus.busy_o === 1'b0);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL idle_wait: busy stayed 1 (cycle %0d)", cyc);
    end
    step(2);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    int rb, sb, fb, hb;
    bit ok;
    for (int i = 0; i < 64; i++) begin
      lat[i] = 1;
      yv[i]  = 8'(8'h30 + i);
    end
    lat[0] = 3;  yv[0] = 8'h2A;
    lat[1] = 12; yv[1] = 8'h11;
    lat[2] = 1;  yv[2] = 8'h22;
    lat[3] = 2;  yv[3] = 8'h33;
    lat[4] = 15; yv[4] = 8'h44;
    lat[5] = 0;
    lat[6] = 4;  yv[6] = 8'h66;
    lat[7] = 2;  yv[7] = 8'h77;
    lat[8] = 1;  yv[8] = 8'h88;
    lat[9] = 8;  yv[9] = 8'h99;
    lat[10] = 1; yv[10] = 8'hAA;

    bus.in_valid_i  = 1'b0;
    bus.x1_in_i     = 8'h00;
    bus.x2_in_i     = 8'h00;
    bus.x3_in_i     = 8'h00;
    bus.res_ready_i = 1'b1;
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    chk("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
    chk("rst_ctl", {bus.dt_start_o, bus.res_valid_o, bus.busy_o,
                    bus.res_err_o}, 32'd0);
    chk("rst_data", {bus.res_y_o, bus.res_tag_o, bus.dt_x1_o,
                     bus.dt_x2_o}, 32'd0);

    // single request
    rb = rlog.size(); sb = start_log.size(); fb = first_log.size();
    push1(8'd1, 8'd4, 8'd7);
    wait_idle(100);
    chk("s1_count", rlog.size(), rb + 1);
    if (rlog.size() > rb)
      chk("s1_res", 32'(rlog[rb]), {8'h2A, 4'd0, 1'b0});
    if (first_log.size() > fb && start_log.size() > sb)
      chk("s1_latency", first_log[fb] - start_log[sb], 32'd4);

    // five back-to-back with a stalled tree
    pulse_reset();
    rb = rlog.size(); sb = start_log.size(); fb = first_log.size();
    push1(8'd1, 8'd2, 8'd3);
    push1(8'd4, 8'd5, 8'd6);
    push1(8'd7, 8'd8, 8'd9);
    push1(8'd10, 8'd11, 8'd12);
    push1(8'd13, 8'd14, 8'd15);
    chk("s2_full", 32'(bus.in_ready_o), 32'd0);
    wait_idle(400);
    chk("s2_count", rlog.size(), rb + 5);
    if (rlog.size() >= rb + 5) begin
      chk("s2_r0", 32'(rlog[rb]),   {8'h11, 4'd0, 1'b0});
      chk("s2_r1", 32'(rlog[rb+1]), {8'h22, 4'd1, 1'b0});
      chk("s2_r2", 32'(rlog[rb+2]), {8'h33, 4'd2, 1'b0});
      chk("s2_tie", 32'(rlog[rb+3]), {8'h44, 4'd3, 1'b0});
      chk("s2_tmo", 32'(rlog[rb+4]), {8'h00, 4'd4, 1'b1});
    end
    if (first_log.size() >= fb + 5 && start_log.size() >= sb + 5) begin
      chk("s2_tie_lat", first_log[fb+3] - start_log[sb+3], 32'd16);
      chk("s2_tmo_lat", first_log[fb+4] - start_log[sb+4], 32'd16);
    end

    // normal issue after a timeout
    rb = rlog.size();
    push1(8'd5, 8'd6, 8'd7);
    wait_idle(100);
    if (rlog.size() > rb)
      chk("s3_res", 32'(rlog[rb]), {8'h66, 4'd5, 1'b0});
    else
      chk("s3_count", rlog.size(), rb + 1);

    // stray tree valid while idle
    rb = rlog.size(); fb = first_log.size();
    stray = 1;
    step(1);
    stray = 0;
    step(4);
    chk("s4_no_res", rlog.size() + first_log.size(), rb + fb);
    chk("s4_idle", {bus.busy_o, bus.res_valid_o}, 32'd0);

    // downstream stall in HOLD
    rb = rlog.size(); sb = start_log.size(); hb = hs_log.size();
    bus.res_ready_i = 1'b0;
    push1(8'h10, 8'h20, 8'h30);
    push1(8'h40, 8'h50, 8'h60);
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = (bus.res_valid_o === 1'b1);
    end
    chk("s5_valid_seen", 32'(ok), 32'd1);
    step(1);
    for (int k = 0; k < 10; k++) begin
      stray = (k == 3);
      step(1);
    end
    stray = 0;
    chk("s5_hold", {bus.res_valid_o, bus.res_y_o}, {1'b1, 8'h77});
    chk("s5_one_start", start_log.size(), sb + 1);
    bus.res_ready_i = 1'b1;
    wait_idle(100);
    chk("s5_count", rlog.size(), rb + 2);
    if (rlog.size() >= rb + 2) begin
      chk("s5_r0", 32'(rlog[rb]),   {8'h77, 4'd6, 1'b0});
      chk("s5_r1", 32'(rlog[rb+1]), {8'h88, 4'd7, 1'b0});
    end
    if (start_log.size() >= sb + 2 && hs_log.size() > hb)
      chk("s5_restart", start_log[sb+1] - hs_log[hb], 32'd2);

    // reset during WAIT with two entries queued
    push1(8'd1, 8'd1, 8'd1);
    push1(8'd2, 8'd2, 8'd2);
    push1(8'd3, 8'd3, 8'd3);
    step(2);
    pulse_reset();
    chk("s6_ctl", {bus.busy_o, bus.in_ready_o, bus.res_valid_o,
                   bus.dt_start_o}, 32'b0100);
    chk("s6_x", {bus.dt_x1_o, bus.dt_x2_o, bus.dt_x3_o}, 32'd0);
    rb = rlog.size();
    step(12);
    push1(8'd9, 8'd9, 8'd9);
    wait_idle(100);
    if (rlog.size() > rb)
      chk("s6_res", 32'(rlog[rb]), {8'hAA, 4'd0, 1'b0});
    else
      chk("s6_count", rlog.size(), rb + 1);

    // tag wrap
    rb = rlog.size();
    for (int i = 0; i < 16; i++)
      push1(8'(i), 8'(i + 1), 8'(i + 2));
    wait_idle(400);
    chk("s7_count", rlog.size(), rb + 16);
    if (rlog.size() >= rb + 16) begin
      chk("s7_tag15", 32'(rlog[rb+14]), {8'h49, 4'hF, 1'b0});
      chk("s7_wrap",  32'(rlog[rb+15]), {8'h4A, 4'h0, 1'b0});
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dt_feature_sequencer.md
Name: dt_feature_sequencer

Overview:
- Initiator for the decision-tree classifier; the classifier is the responder.
- Accepts feature triples (x1, x2, x3) from upstream over a valid/ready handshake and buffers them in a small FIFO.
- Issues them one at a time to the tree via a start pulse, holds the features stable, and waits for the tree's valid result.
- Returns each result with a sequence tag and error flag over a valid/ready output; a per-request timeout guards against a hung tree.

Parameters:
- DATA_W, 8, width of each feature and of the result (matches `DataWidth).
- FIFO_DEPTH, 4, input buffer entries; must be a power of 2, ≥2.
- TAG_W, 4, sequence tag width; tag wraps modulo 2^TAG_W.
- TIMEOUT, 16, cycles in WAIT before a request is abandoned; ≥2.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid_i  in  1  upstream feature triple valid.
- in_ready_o  out  1  FIFO not full.
- x1_in_i / x2_in_i / x3_in_i  in  DATA_W each  upstream features.
- dt_start_o  out  1  one-cycle start pulse to the tree.
- dt_x1_o / dt_x2_o / dt_x3_o  out  DATA_W each  features to the tree; stable from ISSUE until the request leaves WAIT.
- dt_y_i  in  DATA_W  tree result.
- dt_y_valid_i  in  1  tree result valid.
- res_valid_o  out  1  result available.
- res_ready_i  in  1  downstream accepts the result.
- res_y_o  out  DATA_W  result value; 0 on timeout.
- res_tag_o  out  TAG_W  sequence number of the request.
- res_err_o  out  1  request timed out.
- busy_o  out  1  state ≠ IDLE or FIFO not empty.

Behaviour:
- Reset (synchronous, wins over everything, including mid-request):
  - FIFO emptied, state=IDLE, tag counter=0.
  - All outputs 0 except in_ready_o=1 from the first cycle after reset.
  - A request in flight is dropped; a late dt_y_valid_i is ignored.
- Input handshake:
  - Push when in_valid_i && in_ready_o at a clock edge.
  - in_ready_o = !full, combinational from FIFO state.
  - Each accepted triple is stored with tag = tag counter; the counter increments on each push and wraps (e.g. 15 → 0 for TAG_W=4).
- FIFO: simultaneous push and pop when full or empty is legal; count is unchanged, and data ordering is strictly first-in first-out.
- FSM:
  - IDLE: if FIFO non-empty, pop the head into the dt_x*/tag registers and go to ISSUE.
  - ISSUE: dt_start_o=1 for exactly this cycle; clear the timeout counter; go to WAIT.
  - WAIT:
    - Timeout counter increments each cycle.
    - On dt_y_valid_i=1, capture dt_y_i into res_y_o, set res_err_o=0, go to HOLD.
    - Else when the counter reaches TIMEOUT-1, set res_y_o=0 and res_err_o=1, go to HOLD.
    - If both happen in the same cycle, the valid result wins (err=0).
  - HOLD:
    - res_valid_o=1; res_y_o, res_tag_o and res_err_o held stable.
    - When res_ready_i=1, go to IDLE; res_valid_o drops the next cycle.
- Ignored inputs: dt_y_valid_i is ignored in IDLE, ISSUE and HOLD.
- Latency:
  - Push at edge E into an empty FIFO with the FSM in IDLE: dt_start_o is high in the cycle after edge E+1.
  - dt_y_valid_i sampled at edge K: res_valid_o high from edge K.
  - Back-to-back throughput is one request per (tree latency + 3) cycles with res_ready_i tied high.
- dt_x*_o change only when a pop occurs in IDLE.
- Width: all datapaths are DATA_W with no arithmetic on data; the timeout counter is $clog2(TIMEOUT)+1 bits.

Decomposition:
- Shared header, with the existing `DataWidth define:
  - DATA_W default.
  - FSM state encodings (IDLE=0, ISSUE=1, WAIT=2, HOLD=3).
  - Default TIMEOUT value.
- One sub-module: dt_seq_fifo, a synchronous FIFO.
  - Parameters: WIDTH=3*DATA_W+TAG_W, DEPTH.
  - Ports: push, pop, din, dout, full, empty.
  - dout shows the head combinationally.
- The FSM, timeout counter and result registers live in the top.

Test Plan:
- Single request, x=(1,4,7), tree model answers y=0x2A three cycles after start, res_ready_i=1 → one dt_start_o pulse, dt_x* = 1/4/7 stable through WAIT, result res_y_o=0x2A, tag=0, err=0.
- Push 5 triples back-to-back with FIFO_DEPTH=4 and the tree stalled → in_ready_o low after 4 entries held plus 1 issued; results return in order with tags 0–4.
- Tree never responds, TIMEOUT=16 → res_valid_o with y=0, err=1 exactly 16 cycles after the start cycle; the next request then issues normally.
- dt_y_valid_i rises in the same cycle the timeout expires → err=0 and y=the tree value; a stray dt_y_valid_i in IDLE produces no result.
- res_ready_i held low for 10 cycles in HOLD → outputs stable and no new start; the next start occurs 2 cycles after the result handshake.
- Assert reset during WAIT with 2 entries queued → next cycle: FIFO empty, state IDLE, outputs 0, in_ready_o=1; the next push gets tag 0.
